riscv_soc_top: RTL and testbench

Minimal RV32I system-on-chip: a single-cycle RV32I integer core tied to a unified program/data memory (`u_rom`) and a scratch/control memory (`u_ram`). It is the top of the CPU design and has no functional I/O beyond clock and reset. Compliance programs are preloaded into `u_rom._rom` by hierarchical `$readmemh`. Results are observed hierarchically: signature words come from `u_rom`, and signature bounds plus the done flag come from `u_ram`.

---
 rtl/riscv_soc_top.sv | 189 ++++++++++++++++++
 tb/tb_riscv_soc_top.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_soc_top.sv
// Single-cycle RV32I SoC: core plus unified program/data memory (u_rom) and scratch memory (u_ram).
// One instruction retires per clock; no handshakes, so there is no backpressure.

module riscv_soc_rom #(
  parameter int WORDS = 4096
) (
  input  logic        clk,
  input  logic [11:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [11:0] iaddr,
  output logic [31:0] instr
);
  reg [31:0] _rom [0:WORDS-1];

  assign rdata = _rom[addr];
  assign instr = _rom[iaddr];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (be[b]) _rom[addr][8*b +: 8] <= wdata[8*b +: 8];
  end
endmodule

module riscv_soc_ram #(
  parameter int WORDS = 4096
) (
  input  logic        clk,
  input  logic [11:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  reg [31:0] _ram [0:WORDS-1];

  assign rdata = _ram[addr];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (be[b]) _ram[addr][8*b +: 8] <= wdata[8*b +: 8];
  end
endmodule

module riscv_soc_top #(
  parameter int ROM_WORDS = 4096,
  parameter int RAM_WORDS = 4096
) (
  input  logic clk,
  input  logic rst_n
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  localparam logic [6:0] OP_IMM = 7'h13, OP_REG = 7'h33;

  logic [31:0] pc;
  logic [31:0] rf [0:31];
  logic [31:0] instr, rom_instr, rom_rdata, ram_rdata, rd_word;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_u, imm_j, mem_addr;
  logic [31:0] pc_plus4, target, wb_val, st_dat, shifted;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [3:0]  st_be, rom_be, ram_be;
  logic        wb_en, taken;
  logic        unused_bits;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign instr    = (pc[31:28] == 4'h0) ? rom_instr : 32'd0;
  assign rd_word  = (mem_addr[31:28] == 4'h0) ? rom_rdata :
                    (mem_addr[31:28] == 4'h1) ? ram_rdata : 32'd0;
  assign shifted  = rd_word >> {mem_addr[1:0], 3'b000};

  // Stores commit only outside reset so an aborted instruction leaves memory untouched.
  assign rom_be = (!rst_n && mem_addr[31:28] == 4'h0) ? st_be : 4'b0000;
  assign ram_be = (!rst_n && mem_addr[31:28] == 4'h1) ? st_be : 4'b0000;
  assign unused_bits = ^{pc[27:14], mem_addr[27:14]};

  function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = {31'd0, $signed(a) < $signed(b)};
      3'd3: r = {31'd0, a < b};
      3'd4: r = a ^ b;
      3'd5: if (alt) r = $signed(a) >>> b[4:0];
            else     r = a >> b[4:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  always_comb begin
    pc_plus4 = pc + 32'd4;
    target   = pc_plus4;
    wb_en    = 1'b0;
    wb_val   = 32'd0;
    st_be    = 4'b0000;
    st_dat   = 32'd0;
    taken    = 1'b0;
    case (opcode)
      OP_LUI:   begin wb_en = 1'b1; wb_val = imm_u; end
      OP_AUIPC: begin wb_en = 1'b1; wb_val = pc + imm_u; end
      OP_JAL:   begin wb_en = 1'b1; wb_val = pc_plus4; target = pc + imm_j; end
      OP_JALR:  if (f3 == 3'd0) begin
                  wb_en = 1'b1; wb_val = pc_plus4; target = (rs1_val + imm_i) & ~32'd1;
                end
      OP_BR: begin
        case (f3)
          3'd0: taken = rs1_val == rs2_val;
          3'd1: taken = rs1_val != rs2_val;
          3'd4: taken = $signed(rs1_val) <  $signed(rs2_val);
          3'd5: taken = $signed(rs1_val) >= $signed(rs2_val);
          3'd6: taken = rs1_val <  rs2_val;
          3'd7: taken = rs1_val >= rs2_val;
          default: taken = 1'b0;
        endcase
        if (taken) target = pc + imm_b;
      end
      OP_LOAD: begin
        wb_en = 1'b1;
        case (f3)
          3'd0: wb_val = {{24{shifted[7]}}, shifted[7:0]};
          3'd1: wb_val = mem_addr[1] ? {{16{rd_word[31]}}, rd_word[31:16]}
                                     : {{16{rd_word[15]}}, rd_word[15:0]};
          3'd2: wb_val = rd_word;
          3'd4: wb_val = {24'd0, shifted[7:0]};
          3'd5: wb_val = mem_addr[1] ? {16'd0, rd_word[31:16]} : {16'd0, rd_word[15:0]};
          default: wb_en = 1'b0;
        endcase
      end
      OP_STORE: begin
        case (f3)
          3'd0: begin st_be = 4'b0001 << mem_addr[1:0]; st_dat = {4{rs2_val[7:0]}}; end
          3'd1: begin st_be = mem_addr[1] ? 4'b1100 : 4'b0011; st_dat = {2{rs2_val[15:0]}}; end
          3'd2: begin st_be = 4'b1111; st_dat = rs2_val; end
          default: st_be = 4'b0000;
        endcase
      end
      OP_IMM: begin
        wb_en  = (f3 == 3'd1) ? (f7 == 7'h00) :
                 (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        wb_val = alu(f3, (f3 == 3'd5) && instr[30], rs1_val, imm_i);
      end
      OP_REG: begin
        wb_en  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        wb_val = alu(f3, instr[30], rs1_val, rs2_val);
      end
      default: wb_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc <= 32'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      pc <= {target[31:2], 2'b00};
      if (wb_en && rd != 5'd0) rf[rd] <= wb_val;
    end
  end

  riscv_soc_rom #(.WORDS(ROM_WORDS)) u_rom (
    .clk(clk), .addr(mem_addr[13:2]), .be(rom_be), .wdata(st_dat), .rdata(rom_rdata),
    .iaddr(pc[13:2]), .instr(rom_instr)
  );

  riscv_soc_ram #(.WORDS(RAM_WORDS)) u_ram (
    .clk(clk), .addr(mem_addr[13:2]), .be(ram_be), .wdata(st_dat), .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_riscv_soc_top.sv
// Directed program bench for riscv_soc_top: assembles small programs into u_rom and checks state tables.
module tb_riscv_soc_top;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;

  riscv_soc_top #(.ROM_WORDS(4096), .RAM_WORDS(4096)) dut (.clk(clk), .rst_n(rst_n));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;   // 0 reg, 1 rom word, 2 ram word, 3 pc
    int          idx;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        tbl[$];
  logic [31:0] prog[$];
  logic [31:0] sig_exp[4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [31:0] t = imm;
    logic [31:0] a = rs1;
    logic [31:0] f = f3;
    logic [31:0] d = rd;
    return {t[11:0], a[4:0], f[2:0], d[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [31:0] t = imm;
    logic [31:0] b = rs2;
    logic [31:0] a = rs1;
    logic [31:0] f = f3;
    return {t[11:5], b[4:0], a[4:0], f[2:0], t[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] t = imm;
    logic [31:0] b = rs2;
    logic [31:0] a = rs1;
    logic [31:0] f = f3;
    return {t[12], t[10:5], b[4:0], a[4:0], f[2:0], t[4:1], t[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    logic [31:0] s = f7;
    logic [31:0] b = rs2;
    logic [31:0] a = rs1;
    logic [31:0] f = f3;
    logic [31:0] d = rd;
    return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_lui(int imm20, int rd);
    logic [31:0] t = imm20;
    logic [31:0] d = rd;
    return {t[19:0], d[4:0], 7'h37};
  endfunction
  function automatic logic [31:0] enc_jal(int imm, int rd);
    logic [31:0] t = imm;
    logic [31:0] d = rd;
    return {t[20], t[10:1], t[11], t[19:12], d[4:0], 7'h6F};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, 7'h13);
  endfunction

  function automatic logic [31:0] get(int kind, int idx);
    case (kind)
      0: return dut.rf[idx];
      1: return dut.u_rom._rom[idx];
      2: return dut.u_ram._ram[idx];
      default: return dut.pc;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(int kind, int idx, logic [31:0] exp, string name);
    chk_t c;
    c.kind = kind; c.idx = idx; c.exp = exp; c.name = name;
    tbl.push_back(c);
  endtask

  task automatic apply_tbl();
    foreach (tbl[i]) check(tbl[i].name, get(tbl[i].kind, tbl[i].idx), tbl[i].exp);
    tbl.delete();
  endtask

  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds reset for two edges while the program is written into u_rom.
  task automatic boot();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++)
      dut.u_rom._rom[i] = (i < prog.size()) ? prog[i] : 32'd0;
    prog.delete();
    run(2);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ALU and reset
    prog = '{addi(1, 0, 5), addi(2, 1, -7), enc_r(7'h20, 2, 1, 0, 3)};
    boot();
    check("reset_pc", dut.pc, 32'h0);
    check("reset_x1", dut.rf[1], 32'h0);
    rst_n = 1'b0;
    run(3);
    add(0, 1, 32'h5, "alu_x1");
    add(0, 2, 32'hFFFF_FFFE, "alu_x2");
    add(0, 3, 32'h7, "alu_x3");
    add(3, 0, 32'hC, "alu_pc");
    apply_tbl();

    // Memory, byte lanes, unmapped region, x0 and NOP
    prog = '{enc_lui(20'h80FF8, 1), addi(1, 1, -255), addi(2, 0, 32'h100),
             enc_s(0, 1, 2, 2), enc_i(3, 2, 0, 3, 7'h03), enc_i(3, 2, 4, 4, 7'h03),
             enc_i(2, 2, 1, 5, 7'h03), enc_i(0, 2, 5, 6, 7'h03), addi(7, 0, 32'hAA),
             enc_s(1, 7, 2, 0), enc_i(3, 2, 1, 8, 7'h03), enc_lui(20'h20000, 9),
             enc_s(0, 1, 9, 2), enc_i(0, 9, 2, 10, 7'h03), addi(0, 0, 5),
             addi(11, 0, 3), 32'h0000_0000, addi(12, 0, 1)};
    add(1, 0, enc_lui(20'h80FF8, 1), "unmapped_store_rom0");
    boot();
    dut.u_ram._ram[0] = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    run(18);
    add(0, 1, 32'h80FF_7F01, "sw_source");
    add(0, 3, 32'hFFFF_FF80, "lb_103");
    add(0, 4, 32'h0000_0080, "lbu_103");
    add(0, 5, 32'hFFFF_80FF, "lh_102");
    add(0, 6, 32'h0000_7F01, "lhu_100");
    add(1, 64, 32'h80FF_AA01, "sb_101");
    add(0, 8, 32'hFFFF_80FF, "lh_103_odd");
    add(2, 0, 32'hDEAD_BEEF, "unmapped_store_ram0");
    add(0, 10, 32'h0, "unmapped_load");
    add(0, 0, 32'h0, "x0_zero");
    add(0, 11, 32'h3, "x0_reads_zero");
    add(0, 12, 32'h1, "after_nop");
    add(3, 0, 32'h48, "mem_pc");
    apply_tbl();

    // Branches and jumps
    prog = '{addi(1, 0, -1), addi(2, 0, 1), enc_b(8, 2, 1, 4), addi(3, 0, 99),
             enc_b(8, 2, 1, 6), addi(4, 0, 7), addi(0, 0, 0), addi(0, 0, 0),
             enc_jal(8, 1), enc_jal(12, 0), enc_i(1, 1, 0, 0, 7'h67), addi(5, 0, 1),
             addi(6, 0, 6), addi(7, 0, 32'h42), enc_i(0, 7, 0, 8, 7'h67), addi(9, 0, 1),
             addi(10, 0, 10)};
    boot();
    rst_n = 1'b0;
    run(8);
    check("jal_link", dut.rf[1], 32'h24);
    check("jal_pc", dut.pc, 32'h28);
    run(1);
    check("jalr_pc", dut.pc, 32'h24);
    run(1);
    check("jal_fwd_pc", dut.pc, 32'h30);
    run(4);
    add(0, 3, 32'h0, "blt_taken");
    add(0, 4, 32'h7, "bltu_not_taken");
    add(0, 5, 32'h0, "jalr_skip");
    add(0, 6, 32'h6, "after_jal");
    add(0, 8, 32'h3C, "jalr_link");
    add(0, 9, 32'h0, "misaligned_skip");
    add(0, 10, 32'hA, "misaligned_target");
    add(3, 0, 32'h44, "branch_pc");
    apply_tbl();

    // Signature flow
    prog = '{enc_lui(20'h10000, 1), addi(2, 0, 32'h200), enc_s(8, 2, 1, 2),
             addi(3, 0, 32'h210), enc_s(12, 3, 1, 2), addi(4, 0, 32'h11), enc_s(0, 4, 2, 2),
             addi(4, 0, 32'h22), enc_s(4, 4, 2, 2), addi(4, 0, 32'h33), enc_s(8, 4, 2, 2),
             addi(4, 0, 32'h44), enc_s(12, 4, 2, 2), addi(5, 0, 1), enc_s(16, 5, 1, 2),
             enc_jal(0, 0)};
    boot();
    for (int i = 2; i < 5; i++) dut.u_ram._ram[i] = 32'h0;
    rst_n = 1'b0;
    begin
      int cyc = 0;
      while (dut.u_ram._ram[4] !== 32'h1 && cyc < 1000) begin
        run(1);
        cyc++;
      end
    end
    check("sig_done", dut.u_ram._ram[4], 32'h1);
    check("sig_begin", dut.u_ram._ram[2], 32'h200);
    check("sig_end", dut.u_ram._ram[3], 32'h210);
    begin
      int b = int'(dut.u_ram._ram[2] >> 2);
      int e = int'(dut.u_ram._ram[3] >> 2);
      if (e > b && e - b <= 16 && e < 4096)
        for (int a = b; a < e; a++)
          check("sig_word", dut.u_rom._rom[a], (a - b < 4) ? sig_exp[a - b] : 32'hX);
    end

    // Reset asserted while a store executes
    prog = '{addi(1, 0, 5), addi(2, 0, 32'h300), enc_s(0, 1, 2, 2), addi(3, 0, 3)};
    boot();
    dut.u_rom._rom[192] = 32'h1234_5678;
    rst_n = 1'b0;
    run(2);
    check("pre_abort_pc", dut.pc, 32'h8);
    rst_n = 1'b1;
    run(1);
    check("abort_store", dut.u_rom._rom[192], 32'h1234_5678);
    check("abort_pc", dut.pc, 32'h0);
    for (int r = 1; r < 32; r++) add(0, r, 32'h0, "abort_reg_zero");
    apply_tbl();
    rst_n = 1'b0;
    run(1);
    check("restart_x1", dut.rf[1], 32'h5);
    check("restart_pc", dut.pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
